armleocpu_jtag_dmi_ctrl: RTL

//  DR-side controller behind the JTAG TAP: implements RISC-V DTM registers DTMCS and DMI, sequenced by TAP

---
 rtl/armleocpu_jtag_dmi_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/armleocpu_jtag_dmi_ctrl.sv
// rtl/armleocpu_jtag_dmi_ctrl.sv - RISC-V DTM DTMCS/DMI data registers and DMI request/response sequencer
module armleocpu_jtag_dmi_ctrl #(
  parameter int                   IR_LENGTH = 5,
  parameter int                   ABITS     = 7,
  parameter logic [IR_LENGTH-1:0] IR_DTMCS  = 5'h10,
  parameter logic [IR_LENGTH-1:0] IR_DMI    = 5'h11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IR_LENGTH-1:0] ir_i,
  input  logic                 trst_ni,
  input  logic                 capture_i,
  input  logic                 shift_i,
  input  logic                 update_i,
  input  logic                 td_i,
  output logic                 tdo_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [ABITS-1:0]     dmi_req_addr_o,
  output logic [31:0]          dmi_req_data_o,
  output logic [1:0]           dmi_req_op_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic [1:0]           dmi_resp_op_i
);

  localparam int DMI_W = ABITS + 34;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RESP} state_e;

  state_e             fsm_q, fsm_d;
  logic               req_valid_q, req_valid_d;
  logic               resp_ready_q, resp_ready_d;
  logic [ABITS-1:0]   req_addr_q, req_addr_d;
  logic [31:0]        req_data_q, req_data_d;
  logic [1:0]         req_op_q, req_op_d;
  logic [1:0]         dmistat_q, dmistat_d;
  logic [31:0]        dtmcs_sr_q, dtmcs_sr_d;
  logic [DMI_W-1:0]   dmi_sr_q, dmi_sr_d;
  logic [ABITS-1:0]   last_addr_q, last_addr_d;
  logic [31:0]        last_data_q, last_data_d;
  logic               discard_q, discard_d;

  logic               dtmcs_sel, dmi_sel, in_flight;
  logic [1:0]         sr_op;

  assign dtmcs_sel = (ir_i == IR_DTMCS);
  assign dmi_sel   = (ir_i == IR_DMI);
  assign sr_op     = dmi_sr_q[1:0];
  // A transaction finishing this very cycle must not leave discard armed for the next one.
  assign in_flight = (fsm_q == S_REQ) || ((fsm_q == S_WAIT_RESP) && !dmi_resp_valid_i);

  always_comb begin
    fsm_d       = fsm_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_op_d    = req_op_q;
    dmistat_d   = dmistat_q;
    dtmcs_sr_d  = dtmcs_sr_q;
    dmi_sr_d    = dmi_sr_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    discard_d   = discard_q;

    case (fsm_q)
      S_REQ: if (dmi_req_ready_i) fsm_d = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (dmi_resp_valid_i) begin
          fsm_d = S_IDLE;
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            if (req_op_q == 2'd1) last_data_d = dmi_resp_data_i;
            if ((dmistat_q == 2'd0) && (dmi_resp_op_i != 2'd0)) dmistat_d = dmi_resp_op_i;
          end
        end
      end
      default: ;
    endcase

    // TAP-side events are applied after the response so busy/reset override it.
    if (!trst_ni) begin
      dmistat_d  = 2'd0;
      dtmcs_sr_d = '0;
      dmi_sr_d   = '0;
      if (in_flight) discard_d = 1'b1;
    end else if (capture_i) begin
      if (dtmcs_sel) begin
        dtmcs_sr_d = {14'b0, 2'b0, 1'b0, 3'd1, dmistat_q, 6'(ABITS), 4'd1};
      end else if (dmi_sel) begin
        if (fsm_q != S_IDLE) begin
          dmi_sr_d = {last_addr_q, 32'h0, 2'd3};
          if (dmistat_q == 2'd0) dmistat_d = 2'd3;
        end else begin
          dmi_sr_d = {last_addr_q, last_data_q, dmistat_q};
        end
      end
    end else if (shift_i) begin
      if (dtmcs_sel)    dtmcs_sr_d = {td_i, dtmcs_sr_q[31:1]};
      else if (dmi_sel) dmi_sr_d   = {td_i, dmi_sr_q[DMI_W-1:1]};
    end else if (update_i) begin
      if (dtmcs_sel) begin
        if (dtmcs_sr_q[17]) begin
          dmistat_d = 2'd0;
          if (in_flight) discard_d = 1'b1;
        end else if (dtmcs_sr_q[16]) begin
          dmistat_d = 2'd0;
        end
      end else if (dmi_sel) begin
        if (fsm_q != S_IDLE) begin
          if (dmistat_q == 2'd0) dmistat_d = 2'd3;
        end else if ((dmistat_q == 2'd0) && ((sr_op == 2'd1) || (sr_op == 2'd2))) begin
          fsm_d       = S_REQ;
          req_addr_d  = dmi_sr_q[DMI_W-1:34];
          req_data_d  = dmi_sr_q[33:2];
          req_op_d    = sr_op;
          last_addr_d = dmi_sr_q[DMI_W-1:34];
        end
      end
    end

    req_valid_d  = (fsm_d == S_REQ);
    resp_ready_d = (fsm_d == S_WAIT_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= S_IDLE;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_op_q     <= '0;
      dmistat_q    <= '0;
      dtmcs_sr_q   <= '0;
      dmi_sr_q     <= '0;
      last_addr_q  <= '0;
      last_data_q  <= '0;
      discard_q    <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      req_valid_q  <= req_valid_d;
      resp_ready_q <= resp_ready_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_op_q     <= req_op_d;
      dmistat_q    <= dmistat_d;
      dtmcs_sr_q   <= dtmcs_sr_d;
      dmi_sr_q     <= dmi_sr_d;
      last_addr_q  <= last_addr_d;
      last_data_q  <= last_data_d;
      discard_q    <= discard_d;
    end
  end

  assign tdo_o            = dtmcs_sel ? dtmcs_sr_q[0] : (dmi_sel ? dmi_sr_q[0] : 1'b0);
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_resp_ready_o = resp_ready_q;
  assign dmi_req_addr_o   = req_addr_q;
  assign dmi_req_data_o   = req_data_q;
  assign dmi_req_op_o     = req_op_q;

endmodule
